// File: rtl/tx_msg_scheduler_if.sv
// Request/abort/UART handshake and memory-control bundle between the control FSM,
// the TX message scheduler and the message memory / UART transmitter pair.
interface tx_msg_scheduler_if;
    logic       iREQ_START_CONTROL;
    logic       iREQ_INITIAL;
    logic       iREQ_NORMAL;
    logic       iFINISH;
    logic       iUART_BUSY;
    logic       oTX_START_CONTROL;
    logic       oTX_INITIAL;
    logic       oTX_NORMAL;
    logic       oTX_ADVANCE;
    logic       oUART_START;
    logic [5:0] oBYTE_IDX;
    logic       oBUSY;
    logic       oMSG_DONE;
    logic       oOVERRUN;

    modport slave (
        input  iREQ_START_CONTROL, iREQ_INITIAL, iREQ_NORMAL, iFINISH, iUART_BUSY,
        output oTX_START_CONTROL, oTX_INITIAL, oTX_NORMAL, oTX_ADVANCE, oUART_START,
               oBYTE_IDX, oBUSY, oMSG_DONE, oOVERRUN
    );

    modport master (
        output iREQ_START_CONTROL, iREQ_INITIAL, iREQ_NORMAL, iFINISH, iUART_BUSY,
        input  oTX_START_CONTROL, oTX_INITIAL, oTX_NORMAL, oTX_ADVANCE, oUART_START,
               oBYTE_IDX, oBUSY, oMSG_DONE, oOVERRUN
    );
endinterface

// File: rtl/tx_msg_scheduler.sv
// TX status-message scheduler: latches message requests, grants one message at a time
// by fixed priority and paces memory byte advances against the UART busy handshake.
module tx_msg_scheduler #(
    parameter int MSG_LEN    = 35,
    parameter int GAP_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    tx_msg_scheduler_if.slave bus
);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_GRANT     = 4'd1;
    localparam logic [3:0] S_ADVANCE   = 4'd2;
    localparam logic [3:0] S_LOAD      = 4'd3;
    localparam logic [3:0] S_SEND      = 4'd4;
    localparam logic [3:0] S_WAIT_ACK  = 4'd5;
    localparam logic [3:0] S_WAIT_DONE = 4'd6;
    localparam logic [3:0] S_DONE      = 4'd7;
    localparam logic [3:0] S_GAP       = 4'd8;

    localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [5:0]    LAST_IDX = 6'(MSG_LEN - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // Request vectors are ordered [0] start-control, [1] initial, [2] normal.
    function automatic logic [2:0] prio_sel(input logic [2:0] pend);
        logic [2:0] sel;
        if (pend[0]) begin
            sel = 3'b001;
        end else if (pend[1]) begin
            sel = 3'b010;
        end else if (pend[2]) begin
            sel = 3'b100;
        end else begin
            sel = 3'b000;
        end
        return sel;
    endfunction

    logic [3:0]    state_q, state_d;
    logic [2:0]    pending_q, pending_d;
    logic [2:0]    mode_q, mode_d;
    logic [5:0]    byte_idx_q, byte_idx_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          adv_q, adv_d, start_q, start_d, done_q, done_d;
    logic          busy_q, busy_d, overrun_q, overrun_d;
    logic [2:0]    req_s, grant_s;

    // Next state, request latching and overrun detection; abort overrides everything
    always_comb begin
        req_s   = {bus.iREQ_NORMAL, bus.iREQ_INITIAL, bus.iREQ_START_CONTROL};
        grant_s = 3'b000;
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q != 3'b000) begin
                    state_d = S_GRANT;
                    grant_s = prio_sel(pending_q);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT:     state_d = S_ADVANCE;
            S_ADVANCE:   state_d = S_LOAD;
            S_LOAD:      state_d = bus.iUART_BUSY ? S_LOAD : S_SEND;
            S_SEND:      state_d = S_WAIT_ACK;
            S_WAIT_ACK:  state_d = bus.iUART_BUSY ? S_WAIT_DONE : S_WAIT_ACK;
            S_WAIT_DONE: begin
                if (bus.iUART_BUSY) begin
                    state_d = S_WAIT_DONE;
                end else if (byte_idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ADVANCE;
                end
            end
            S_DONE:      state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            S_GAP:       state_d = (gap_cnt_q == {GW{1'b0}}) ? S_IDLE : S_GAP;
            default:     state_d = S_IDLE;
        endcase
        if (bus.iFINISH) begin
            state_d   = S_IDLE;
            grant_s   = 3'b000;
            pending_d = 3'b000;
            overrun_d = 1'b0;
        end else begin
            pending_d = (pending_q & ~grant_s) | req_s;
            overrun_d = |(req_s & pending_q & ~grant_s);
        end
    end

    // Output and datapath next values, decoded from the next state so outputs are flops
    always_comb begin
        adv_d   = (state_d == S_ADVANCE);
        start_d = (state_d == S_SEND);
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_GRANT:                                           mode_d = grant_s;
            S_ADVANCE, S_LOAD, S_SEND, S_WAIT_ACK, S_WAIT_DONE: mode_d = mode_q;
            default:                                           mode_d = 3'b000;
        endcase
        if (state_d == S_IDLE || state_d == S_GRANT) begin
            byte_idx_d = 6'd0;
        end else if (state_q == S_WAIT_DONE && state_d == S_ADVANCE) begin
            byte_idx_d = byte_idx_q + 6'd1;
        end else begin
            byte_idx_d = byte_idx_q;
        end
        if (state_d == S_GAP && state_q == S_DONE) begin
            gap_cnt_d = GAP_LOAD;
        end else if (state_d == S_GAP) begin
            gap_cnt_d = gap_cnt_q - GW'(1);
        end else begin
            gap_cnt_d = {GW{1'b0}};
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pending_q  <= 3'b000;
            mode_q     <= 3'b000;
            byte_idx_q <= 6'd0;
            gap_cnt_q  <= {GW{1'b0}};
            adv_q      <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            mode_q     <= mode_d;
            byte_idx_q <= byte_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            adv_q      <= adv_d;
            start_q    <= start_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.oTX_START_CONTROL = mode_q[0];
    assign bus.oTX_INITIAL       = mode_q[1];
    assign bus.oTX_NORMAL        = mode_q[2];
    assign bus.oTX_ADVANCE       = adv_q;
    assign bus.oUART_START       = start_q;
    assign bus.oBYTE_IDX         = byte_idx_q;
    assign bus.oBUSY             = busy_q;
    assign bus.oMSG_DONE         = done_q;
    assign bus.oOVERRUN          = overrun_q;
endmodule

// File: tb/tb_tx_msg_scheduler.sv
// Randomized bench: a message-timeline model plans expected strobes, which a
// separate monitor pops and compares against the scheduler outputs.
module tb_tx_msg_scheduler;
    localparam int L       = 4;
    localparam int GAP     = 3;
    localparam int MAXC    = 8192;
    localparam int RUNC    = 6000;
    localparam int STOPREQ = 5500;
    localparam int K_ADV   = 0;
    localparam int K_START = 1;
    localparam int K_DONE  = 2;
    localparam int K_OVR   = 3;

    typedef struct {
        int         cyc;
        logic [2:0] mode;
        int         idx;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tx_msg_scheduler_if bus ();
    tx_msg_scheduler #(.MSG_LEN(L), .GAP_CYCLES(GAP)) dut (.clk(clk), .reset(reset), .bus(bus));

    ev_t        evq [4][$];
    logic       busy_map [MAXC];
    logic [2:0] exp_mode [MAXC];
    logic       exp_busy [MAXC];
    int         checks  = 0;
    int         errors  = 0;
    int         cyc     = -1;
    bit         mon_en  = 1'b0;
    logic [2:0] pend    = 3'b000;
    int         idle_at = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    // Lay out one whole message on the timeline: byte period is busy length + 4.
    task automatic plan_msg(input int g, input logic [2:0] m);
        int  h, s, n, d;
        ev_t e;
        d = 0;
        h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 50)) : 0;
        for (int k = 0; k < h; k++) busy_map[g + 2 + k] = 1'b1;
        s = g + 3 + h;
        for (int i = 0; i < L; i++) begin
            e.mode = m; e.idx = i;
            e.cyc = (i == 0) ? g + 1 : s - 2;
            evq[K_ADV].push_back(e);
            e.cyc = s;
            evq[K_START].push_back(e);
            n = $urandom_range(1, 6);
            for (int k = 1; k <= n; k++) busy_map[s + k] = 1'b1;
            if (i < L - 1) s = s + n + 4;
            else d = s + n + 2;
        end
        e.cyc = d; e.mode = m; e.idx = L - 1;
        evq[K_DONE].push_back(e);
        for (int c = g; c < d; c++) exp_mode[c] = m;
        idle_at = d + 1 + GAP;
        for (int c = g; c < idle_at; c++) exp_busy[c] = 1'b1;
    endtask

    task automatic flush(input int c);
        pend    = 3'b000;
        idle_at = c + 1;
        for (int k = c + 1; k < MAXC; k++) begin
            busy_map[k] = 1'b0; exp_mode[k] = 3'b000; exp_busy[k] = 1'b0;
        end
        for (int k = 0; k < 4; k++)
            while (evq[k].size() > 0 && evq[k][$].cyc > c) void'(evq[k].pop_back());
    endtask

    task automatic pop_cmp(input int k, input logic pulse, input string name, input logic [2:0] mode_s);
        ev_t e;
        if (pulse) begin
            if (evq[k].size() == 0) begin
                checks++; errors++;
                $display("FAIL %s unexpected pulse at cyc=%0d, want none", name, cyc);
            end else begin
                e = evq[k].pop_front();
                chk({name, "_cyc"}, cyc, e.cyc);
                if (k == K_ADV || k == K_START) begin
                    chk({name, "_mode"}, int'(mode_s), int'(e.mode));
                    chk({name, "_idx"}, int'(bus.oBYTE_IDX), e.idx);
                end
            end
        end else if (evq[k].size() > 0 && evq[k][0].cyc <= cyc) begin
            e = evq[k].pop_front();
            checks++; errors++;
            $display("FAIL %s missing: got no pulse at cyc=%0d, want pulse at cyc=%0d", name, cyc, e.cyc);
        end
    endtask

    initial begin : monitor
        logic [2:0] mode_s;
        forever begin
            @(negedge clk);
            if (mon_en && cyc >= 0) begin
                mode_s = {bus.oTX_NORMAL, bus.oTX_INITIAL, bus.oTX_START_CONTROL};
                chk("mode", int'(mode_s), int'(exp_mode[cyc]));
                chk("obusy", int'(bus.oBUSY), int'(exp_busy[cyc]));
                pop_cmp(K_ADV, bus.oTX_ADVANCE, "advance", mode_s);
                pop_cmp(K_START, bus.oUART_START, "uart_start", mode_s);
                pop_cmp(K_DONE, bus.oMSG_DONE, "msg_done", mode_s);
                pop_cmp(K_OVR, bus.oOVERRUN, "overrun", mode_s);
            end
        end
    end

    initial begin : stimulus
        logic [2:0] req, clr;
        bit         fin, seen;
        ev_t        e;
        for (int k = 0; k < MAXC; k++) begin
            busy_map[k] = 1'b0; exp_mode[k] = 3'b000; exp_busy[k] = 1'b0;
        end
        bus.iREQ_START_CONTROL = 1'b0; bus.iREQ_INITIAL = 1'b0; bus.iREQ_NORMAL = 1'b0;
        bus.iFINISH = 1'b0; bus.iUART_BUSY = 1'b0;
        #12;
        chk("rst_mode", int'({bus.oTX_NORMAL, bus.oTX_INITIAL, bus.oTX_START_CONTROL}), 0);
        chk("rst_strobes", int'({bus.oTX_ADVANCE, bus.oUART_START, bus.oMSG_DONE, bus.oOVERRUN}), 0);
        chk("rst_busy", int'(bus.oBUSY), 0);
        chk("rst_idx", int'(bus.oBYTE_IDX), 0);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int c = 0; c < RUNC; c++) begin
            @(posedge clk);
            cyc = c;
            #1;
            req = 3'b000;
            fin = 1'b0;
            if (c < STOPREQ) begin
                for (int b = 0; b < 3; b++) req[b] = ($urandom_range(0, 24) == 0);
                fin = ($urandom_range(0, 249) == 0);
            end
            bus.iREQ_START_CONTROL = req[0];
            bus.iREQ_INITIAL       = req[1];
            bus.iREQ_NORMAL        = req[2];
            bus.iFINISH            = fin;
            bus.iUART_BUSY         = busy_map[c];
            if (fin) begin
                flush(c);
            end else begin
                clr = 3'b000;
                if (c >= idle_at && pend != 3'b000) begin
                    clr = pend & (~pend + 3'd1);
                    plan_msg(c + 1, clr);
                end
                if ((req & pend & ~clr) != 3'b000) begin
                    e.cyc = c + 1; e.mode = 3'b000; e.idx = 0;
                    evq[K_OVR].push_back(e);
                end
                pend = (pend & ~clr) | req;
            end
        end
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        bus.iREQ_START_CONTROL = 1'b0; bus.iREQ_INITIAL = 1'b0; bus.iREQ_NORMAL = 1'b0;
        bus.iFINISH = 1'b0; bus.iUART_BUSY = 1'b0;
        for (int k = 0; k < 4; k++) chk($sformatf("leftover_q%0d", k), evq[k].size(), 0);

        // Reset in the middle of a byte, with another message type pending.
        @(posedge clk); #1;
        bus.iREQ_NORMAL = 1'b1;
        @(posedge clk); #1;
        bus.iREQ_NORMAL = 1'b0; bus.iREQ_INITIAL = 1'b1;
        @(posedge clk); #1;
        bus.iREQ_INITIAL = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (bus.oUART_START) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL start_timeout got no oUART_START within 20 cycles, want one");
        end else begin
            @(posedge clk); #1;
            bus.iUART_BUSY = 1'b1;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("pre_reset_mode", int'({bus.oTX_NORMAL, bus.oTX_INITIAL, bus.oTX_START_CONTROL}), 4);
            chk("pre_reset_busy", int'(bus.oBUSY), 1);
            #2 reset = 1'b1;
            #1;
            chk("async_rst_mode", int'({bus.oTX_NORMAL, bus.oTX_INITIAL, bus.oTX_START_CONTROL}), 0);
            chk("async_rst_strobes", int'({bus.oTX_ADVANCE, bus.oUART_START, bus.oMSG_DONE, bus.oOVERRUN}), 0);
            chk("async_rst_busy", int'(bus.oBUSY), 0);
            chk("async_rst_idx", int'(bus.oBYTE_IDX), 0);
            @(negedge clk);
            reset = 1'b0;
            bus.iUART_BUSY = 1'b0;
            for (int t = 0; t < 6; t++) begin
                @(negedge clk);
                chk("post_rst_no_grant", int'({bus.oBUSY, bus.oTX_INITIAL, bus.oTX_NORMAL}), 0);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_msg_scheduler.md
# tx_msg_scheduler

Sequences the TX status-message memory and shares it between three message requesters (start-control, initial, normal). Latches request pulses, grants one message at a time by priority, holds the one-hot mode select to the message memory, and paces byte advances against the UART transmitter's busy handshake. Sits between the control FSM and the message memory / UART TX pair; replaces direct level-driving of the memory mode inputs.

## Interface
- MSG_LEN, 35: bytes per message (memory table length); legal 1..63
- GAP_CYCLES, 1000: idle clocks inserted after each completed message; 0 = no gap
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- iREQ_START_CONTROL  in  1  request start-control message (sampled each cycle; high = request)
- iREQ_INITIAL  in  1  request initial-state message
- iREQ_NORMAL  in  1  request normal-state message
- iFINISH  in  1  abort: flush pending requests and current message
- iUART_BUSY  in  1  UART transmitter busy (high from cycle after start until byte shifted out)
- oTX_START_CONTROL  out  1  mode select to memory, one-hot with next two
- oTX_INITIAL  out  1  mode select
- oTX_NORMAL  out  1  mode select
- oTX_ADVANCE  out  1  one-cycle strobe advancing memory byte pointer
- oUART_START  out  1  one-cycle strobe loading memory output byte into UART
- oBYTE_IDX  out  6  index of byte in flight, 0..MSG_LEN-1
- oBUSY  out  1  high in any state except IDLE
- oMSG_DONE  out  1  one-cycle pulse on message completion
- oOVERRUN  out  1  one-cycle pulse: request arrived while same type already pending

## Operation
- Pending register, 3 bits (SC, INI, NOR). Bit set on any cycle its request is high; cleared when granted. Request high while its bit already set and not being cleared that cycle -> oOVERRUN next cycle, request not double-counted.
- Request for the type currently transmitting sets its pending bit (re-sent after current message).
- Arbitration in IDLE: SC > INI > NOR, fixed priority, no preemption of a message in progress.
- States: IDLE -> GRANT -> ADVANCE -> LOAD -> SEND -> WAIT_ACK -> WAIT_DONE -> (ADVANCE | DONE) ; DONE -> GAP -> IDLE (DONE -> IDLE if GAP_CYCLES=0).
- GRANT: selected mode output high, oBYTE_IDX=0, granted pending bit cleared. Mode stays high through WAIT_DONE of last byte; low from DONE onward.
- ADVANCE: oTX_ADVANCE=1 for exactly one cycle.
- LOAD: memory byte settles; stays while iUART_BUSY=1; exits to SEND when iUART_BUSY=0.
- SEND: oUART_START=1 one cycle.
- WAIT_ACK: waits for iUART_BUSY=1. WAIT_DONE: waits for iUART_BUSY=0; then if oBYTE_IDX==MSG_LEN-1 -> DONE, else oBYTE_IDX+1 -> ADVANCE.
- DONE: oMSG_DONE=1 one cycle. GAP: counter loaded GAP_CYCLES-1, decrements to 0, then IDLE. Requests still latch during GAP.
- iFINISH=1 (any state): next state IDLE, pending cleared, all mode/strobe outputs 0, oBYTE_IDX=0, no oMSG_DONE. iFINISH wins over same-cycle requests (those requests dropped). Requests in cycles after iFINISH falls latch normally.
- oBYTE_IDX width 6; never exceeds MSG_LEN-1, no wrap.

## Timing
- All outputs registered/state-decoded, glitch-free.
- Reset values: all outputs 0, state IDLE, pending 000, GAP counter 0.
- Request high at edge k (IDLE, no higher pending): GRANT/mode high after edge k+1, oTX_ADVANCE high after k+2, LOAD after k+3, oUART_START high after k+4 if iUART_BUSY=0 during LOAD.
- Per byte, UART busy N cycles beginning cycle after SEND: byte period = N+4 clocks (ADVANCE, LOAD, SEND, WAIT_ACK 1, WAIT_DONE N... exit on first busy-low sample).
- Exactly MSG_LEN oTX_ADVANCE and MSG_LEN oUART_START pulses per completed message; oTX_ADVANCE always precedes its oUART_START by 2 cycles minimum.
- Reset mid-message: immediate async clear, no further strobes.

## Test plan
- Single NOR request, UART busy 10 cycles per byte -> oTX_NORMAL high 35 bytes, 35 advances, 35 starts, oBYTE_IDX 0..34, oMSG_DONE once, then 1000 idle cycles before next grant.
- SC, INI, NOR requested same cycle -> messages sent SC, then INI, then NOR; each mode one-hot, no overlap, two GAP intervals between.
- NOR pending, NOR requested again -> oOVERRUN one pulse; NOR sent once more only.
- iFINISH asserted at byte 12 with INI pending -> outputs 0 next cycle, no oMSG_DONE, INI not sent; new request afterward restarts at byte 0.
- iUART_BUSY held high on grant for 50 cycles -> stays in LOAD, oUART_START issued only after busy falls; MSG_LEN=1, GAP_CYCLES=0 -> one byte then IDLE next cycle after DONE.
- Reset asserted mid-WAIT_DONE -> all outputs 0 asynchronously, pending 000.
